// File: rtl/instr_q_pkg.sv
// Shared instruction-queue constants and the occupancy-width helper; also used by the controller.
package instr_q_pkg;

   localparam int DEF_DATA_WIDTH = 64;
   localparam int DEF_DEPTH      = 64;

   // Occupancy must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/instr_q_ram.sv
// Simple dual-port storage: synchronous write, synchronous read, one cycle read latency.
// Contents are never reset; the read register is free-running.
module instr_q_ram #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 64,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                  external_clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge external_clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/instr_queue_param.sv
// FWFT instruction queue: a push into an empty queue shows on out_data one edge later, no bypass.
// Backpressure via in_ready when BLOCKING=1; otherwise writes to a full queue are dropped and flagged.
module instr_queue_param
   import instr_q_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_THRESH  = DEPTH - 4,
   parameter int AE_THRESH  = 2,
   parameter int BLOCKING   = 1,
   localparam int CNT_W     = cnt_w(DEPTH)
) (
   input  logic                  external_clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [CNT_W-1:0]      occupancy,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_THRESH);
   localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO_CNT  = CNT_W'(2);

   logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_ptr_nxt, rd_addr;
   logic [CNT_W-1:0]      occ;
   logic [DATA_WIDTH-1:0] out_q, ram_rd, bp_q, next_val;
   logic                  bp_sel, full, push, pop;

   assign full      = (occ == FULL_CNT);
   assign out_valid = (occ != '0);
   assign push      = in_valid && !full;
   assign pop       = out_valid && out_ready;

   assign in_ready     = (BLOCKING == 0) ? 1'b1 : !full;
   assign occupancy    = occ;
   assign almost_full  = (occ >= AF_CNT);
   assign almost_empty = (occ <= AE_CNT);
   assign out_data     = out_q;

   // The RAM always prefetches the entry behind the post-edge head, so a pop can refill
   // out_q without a bubble; bp_q covers the case where that entry is written on the same edge.
   assign rd_ptr_nxt = flush ? '0 : (pop ? rd_ptr + 1'b1 : rd_ptr);
   assign rd_addr    = rd_ptr_nxt + 1'b1;
   assign next_val   = bp_sel ? bp_q : ram_rd;

   instr_q_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .external_clk (external_clk),
      .wr_en        (push && !flush),
      .wr_addr      (wr_ptr),
      .wr_data      (in_data),
      .rd_addr      (rd_addr),
      .rd_data      (ram_rd)
   );

   always_ff @(posedge external_clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
         overflow <= 1'b0;
         out_q    <= '0;
         bp_sel   <= 1'b0;
         bp_q     <= '0;
      end else if (flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         occ      <= '0;
         overflow <= 1'b0;
         bp_sel   <= 1'b0;
      end else begin
         rd_ptr <= rd_ptr_nxt;
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
            bp_q   <= in_data;
         end
         if (push && !pop) begin
            occ <= occ + 1'b1;
         end else if (pop && !push) begin
            occ <= occ - 1'b1;
         end
         if (BLOCKING == 0 && in_valid && full) begin
            overflow <= 1'b1;
         end
         bp_sel <= push && (wr_ptr == rd_addr);
         // New head comes from storage when one remains behind it, else from the incoming word.
         if (pop && occ >= TWO_CNT) begin
            out_q <= next_val;
         end else if (push && (occ == '0 || (occ == ONE_CNT && pop))) begin
            out_q <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_instr_queue_param.sv
// Scoreboard bench for instr_queue_param: one blocking and one dropping DEPTH=4 instance.
module tb_instr_queue_param;

   localparam int DW = 16;
   localparam int CW = 3;

   logic external_clk = 1'b0;
   logic rst = 1'b1;
   logic flush = 1'b0;

   logic [DW-1:0] a_in_data = '0, b_in_data = '0;
   logic          a_in_valid = 1'b0, b_in_valid = 1'b0;
   logic          a_out_ready = 1'b0, b_out_ready = 1'b0;
   logic          a_in_ready, b_in_ready, a_out_valid, b_out_valid;
   logic [DW-1:0] a_out_data, b_out_data;
   logic [CW-1:0] a_occ, b_occ;
   logic          a_af, b_af, a_ae, b_ae, a_ovf, b_ovf;

   int checks = 0;
   int failures = 0;

   int            mcnt [2];
   bit            movf [2];
   logic [DW-1:0] sba [$];
   logic [DW-1:0] sbb [$];

   always #5 external_clk = ~external_clk;

   instr_queue_param #(
      .DATA_WIDTH (DW), .DEPTH (4), .AF_THRESH (3), .AE_THRESH (2), .BLOCKING (1)
   ) dut_a (
      .external_clk (external_clk), .rst (rst), .flush (flush),
      .in_data (a_in_data), .in_valid (a_in_valid), .in_ready (a_in_ready),
      .out_data (a_out_data), .out_valid (a_out_valid), .out_ready (a_out_ready),
      .occupancy (a_occ), .almost_full (a_af), .almost_empty (a_ae), .overflow (a_ovf)
   );

   instr_queue_param #(
      .DATA_WIDTH (DW), .DEPTH (4), .AF_THRESH (3), .AE_THRESH (2), .BLOCKING (0)
   ) dut_b (
      .external_clk (external_clk), .rst (rst), .flush (flush),
      .in_data (b_in_data), .in_valid (b_in_valid), .in_ready (b_in_ready),
      .out_data (b_out_data), .out_valid (b_out_valid), .out_ready (b_out_ready),
      .occupancy (b_occ), .almost_full (b_af), .almost_empty (b_ae), .overflow (b_ovf)
   );

   task automatic clear_model();
      mcnt[0] = 0; mcnt[1] = 0;
      movf[0] = 1'b0; movf[1] = 1'b0;
      sba.delete();
      sbb.delete();
   endtask

   // One clock of stimulus on instance d, with all status outputs checked against the model first.
   task automatic step(input int d, input bit vld, input logic [DW-1:0] dat, input bit rdy, input bit fl);
      logic [DW-1:0] od, exp_head;
      logic [CW-1:0] oc;
      logic ov, ir, af, ae, of;
      bit push_m, pop_m;
      @(negedge external_clk);
      a_in_valid = (d == 0) && vld; a_in_data = dat; a_out_ready = (d == 0) && rdy;
      b_in_valid = (d == 1) && vld; b_in_data = dat; b_out_ready = (d == 1) && rdy;
      flush = fl;
      #1;
      if (d == 0) begin
         od = a_out_data; oc = a_occ; ov = a_out_valid; ir = a_in_ready;
         af = a_af; ae = a_ae; of = a_ovf;
         exp_head = (sba.size() > 0) ? sba[0] : '0;
      end else begin
         od = b_out_data; oc = b_occ; ov = b_out_valid; ir = b_in_ready;
         af = b_af; ae = b_ae; of = b_ovf;
         exp_head = (sbb.size() > 0) ? sbb[0] : '0;
      end
      checks++;
      if (oc !== CW'(mcnt[d])) begin failures++; $display("FAIL occupancy dut%0d got=%0d exp=%0d", d, oc, mcnt[d]); end
      checks++;
      if (ov !== (mcnt[d] != 0)) begin failures++; $display("FAIL out_valid dut%0d got=%b exp=%b", d, ov, mcnt[d] != 0); end
      if (mcnt[d] != 0) begin
         checks++;
         if (od !== exp_head) begin failures++; $display("FAIL out_data dut%0d got=%h exp=%h", d, od, exp_head); end
      end
      checks++;
      if (ir !== ((d == 1) || (mcnt[d] < 4))) begin failures++; $display("FAIL in_ready dut%0d got=%b cnt=%0d", d, ir, mcnt[d]); end
      checks++;
      if (af !== (mcnt[d] >= 3)) begin failures++; $display("FAIL almost_full dut%0d got=%b cnt=%0d", d, af, mcnt[d]); end
      checks++;
      if (ae !== (mcnt[d] <= 2)) begin failures++; $display("FAIL almost_empty dut%0d got=%b cnt=%0d", d, ae, mcnt[d]); end
      checks++;
      if (of !== movf[d]) begin failures++; $display("FAIL overflow dut%0d got=%b exp=%b", d, of, movf[d]); end
      @(posedge external_clk);
      if (fl) begin
         clear_model();
      end else begin
         pop_m  = rdy && (mcnt[d] > 0);
         push_m = vld && (mcnt[d] < 4);
         if (d == 1 && vld && mcnt[d] == 4) movf[1] = 1'b1;
         if (pop_m) begin
            if (d == 0) void'(sba.pop_front()); else void'(sbb.pop_front());
         end
         if (push_m) begin
            if (d == 0) sba.push_back(dat); else sbb.push_back(dat);
         end
         mcnt[d] = mcnt[d] + int'(push_m) - int'(pop_m);
      end
   endtask

   task automatic test_reset();
      clear_model();
      rst = 1'b1;
      repeat (2) @(posedge external_clk);
      @(negedge external_clk);
      checks++;
      if (a_out_data !== '0 || b_out_data !== '0) begin
         failures++; $display("FAIL reset_out_data got=%h/%h exp=0", a_out_data, b_out_data);
      end
      rst = 1'b0;
      step(0, 0, '0, 0, 0);
      step(1, 0, '0, 0, 0);
   endtask

   task automatic test_fill_block();
      for (int i = 0; i < 4; i++) step(0, 1, DW'(16'hA1 + i), 0, 0);
      step(0, 1, 16'hA5, 0, 0);
      step(0, 0, '0, 0, 0);
   endtask

   task automatic test_drain();
      for (int i = 0; i < 4; i++) step(0, 0, '0, 1, 0);
      step(0, 0, '0, 1, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) step(0, 1, DW'(16'hC0 + i), 1, 0);
      step(0, 0, '0, 1, 0);
      step(0, 0, '0, 0, 0);
   endtask

   task automatic test_drop();
      for (int i = 0; i < 6; i++) step(1, 1, DW'(16'hB1 + i), 0, 0);
      step(1, 0, '0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 0, '0, 1, 0);
      step(1, 0, '0, 0, 0);
   endtask

   task automatic test_flush();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 3; i++) step(d, 1, DW'(16'hD0 + i), 0, 0);
         step(d, 1, 16'hEE, 1, 1);
         step(d, 0, '0, 0, 0);
         step(d, 1, 16'h77, 0, 0);
         step(d, 0, '0, 1, 0);
         step(d, 0, '0, 0, 0);
      end
   endtask

   task automatic test_async_reset();
      step(0, 1, 16'h11, 0, 0);
      step(0, 1, 16'h22, 0, 0);
      step(0, 0, '0, 0, 0);
      @(negedge external_clk);
      #1 rst = 1'b1;
      #1;
      checks++;
      if (a_out_valid !== 1'b0) begin failures++; $display("FAIL async_rst_out_valid got=%b exp=0", a_out_valid); end
      checks++;
      if (a_occ !== '0) begin failures++; $display("FAIL async_rst_occupancy got=%0d exp=0", a_occ); end
      #1 rst = 1'b0;
      clear_model();
      step(0, 1, 16'h55, 0, 0);
      step(0, 0, '0, 0, 0);
   endtask

   initial begin
      clear_model();
      test_reset();
      test_fill_block();
      test_drain();
      test_back_to_back();
      test_drop();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
